// File: rtl/matriz_pkg.sv
// Shared matrix coprocessor definitions: operand geometry, RAM layout
// and the fetch sequencer state encoding.
package matriz_pkg;

    localparam int N      = 5;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 8;
    localparam int BASE_A = 0;
    localparam int BASE_B = 25;
    localparam int IDX_W  = 5;
    localparam int RC_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WAIT_B,
        OUT,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/matrix_fetch_if.sv
// RAM read port plus element-pair output handshake of the fetch stage.
interface matrix_fetch_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8
);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [2:0]        out_row;
    logic [2:0]        out_col;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output out_valid, out_last,
        output out_a, out_b, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  out_valid, out_last,
        input  out_a, out_b, out_row, out_col,
        output out_ready
    );

endinterface

// File: rtl/matrix_fetch.sv
// Reads A[i] and B[i] back from the data RAM and presents them pairwise
// to the element-wise arithmetic unit over a valid/ready handshake.
module matrix_fetch #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8,
    parameter int N      = 5,
    parameter int BASE_A = 0,
    parameter int BASE_B = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    matrix_fetch_if.master bus
);

    import matriz_pkg::*;

    fetch_state_e state_q, state_d;
    logic [4:0]        i_q, i_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [2:0]        out_row_q, out_row_d;
    logic [2:0]        out_col_q, out_col_d;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              is_last;

    assign is_last = (i_q == 5'(N*N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            a_q       <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            row_q     <= row_d;
            col_q     <= col_d;
            a_q       <= a_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        row_d     = row_q;
        col_d     = col_q;
        a_d       = a_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_A;
                    i_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RD_A: begin
                mem_rd   = 1'b1;
                mem_addr = ADDR_W'(BASE_A) + ADDR_W'(i_q);
                state_d  = RD_B;
            end
            RD_B: begin
                mem_rd   = 1'b1;
                mem_addr = ADDR_W'(BASE_B) + ADDR_W'(i_q);
                a_d      = bus.mem_rdata;
                state_d  = WAIT_B;
            end
            // Output registers only move here, so they hold under backpressure.
            WAIT_B: begin
                out_a_d   = a_q;
                out_b_d   = bus.mem_rdata;
                out_row_d = row_q;
                out_col_d = col_q;
                state_d   = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + 5'd1;
                        state_d = RD_A;
                        if (col_q == 3'(N-1)) begin
                            col_d = '0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q == RD_A) || (state_q == RD_B) ||
                           (state_q == WAIT_B) || (state_q == OUT);
    assign done          = (state_q == DONE);
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_addr  = mem_addr;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_last  = (state_q == OUT) && is_last;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_matrix_fetch.sv
// Scoreboard bench for matrix_fetch: synchronous RAM model, expected
// pairs and read addresses queued per run and checked as they appear.
module tb_matrix_fetch;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    matrix_fetch_if #(.DATA_W(9), .ADDR_W(8)) bus ();

    matrix_fetch #(
        .DATA_W(9), .ADDR_W(8), .N(5), .BASE_A(0), .BASE_B(25)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] ram [256];

    always @(posedge clk)
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [2:0] r;
        logic [2:0] c;
        logic       last;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] addr_q [$];
    exp_t       e;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic push_job();
        exp_t x;
        for (int i = 0; i < 25; i++) begin
            x.a    = 9'(i + 1);
            x.b    = 9'(i + 26);
            x.r    = 3'(i / 5);
            x.c    = 3'(i % 5);
            x.last = (i == 24);
            sb.push_back(x);
            addr_q.push_back(8'(i));
            addr_q.push_back(8'(25 + i));
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_a"}, bus.out_a, 0);
        chk({tag, "_b"}, bus.out_b, 0);
        chk({tag, "_row"}, bus.out_row, 0);
        chk({tag, "_col"}, bus.out_col, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.mem_rd) begin
                if (addr_q.size() == 0) chk("addr_extra", 1, 0);
                else begin
                    chk("mem_addr", bus.mem_addr, addr_q[0]);
                    addr_q.delete(0);
                end
            end
            if (bus.out_valid) begin
                chk("rd_in_out", bus.mem_rd, 0);
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    e = sb[0];
                    chk("out_a", bus.out_a, e.a);
                    chk("out_b", bus.out_b, e.b);
                    chk("out_row", bus.out_row, e.r);
                    chk("out_col", bus.out_col, e.c);
                    chk("out_last", bus.out_last, e.last);
                    if (bus.out_ready) begin
                        sb.delete(0);
                        hs_cnt++;
                        last_hs_cyc = cyc;
                    end
                end
            end else begin
                chk("last_no_valid", bus.out_last, 0);
            end
        end
    end

    task automatic run_job(int bp_i, int st_i, bit st_done,
                           int rst_i, int exp_busy);
        bit got_done = 1'b0;
        bit bp_fired = 1'b0;
        bit st_fired = 1'b0;
        hs_cnt   = 0;
        busy_cyc = 0;
        done_cnt = 0;
        push_job();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (2) @(posedge clk) #1;
        chk("lat_early", bus.out_valid, 0);
        @(posedge clk) #1;
        chk("lat_valid", bus.out_valid, 1);
        for (int k = 0; k < 400 && !got_done; k++) begin
            if (done) begin
                got_done = 1'b1;
                if (st_done) begin
                    start = 1'b1;
                    @(posedge clk) #1 start = 1'b0;
                end
            end else if (rst_i >= 0 && bus.out_valid && hs_cnt == rst_i) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("mid_rst");
                sb.delete();
                addr_q.delete();
                #10 rst_n = 1'b1;
                return;
            end else if (!bp_fired && bus.out_valid && hs_cnt == bp_i) begin
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk) #1;
                bus.out_ready = 1'b1;
                bp_fired = 1'b1;
            end else if (!st_fired && bus.out_valid && hs_cnt == st_i) begin
                start = 1'b1;
                @(posedge clk) #1 start = 1'b0;
                st_fired = 1'b1;
            end else begin
                @(posedge clk) #1;
            end
        end
        chk("done_seen", got_done, 1);
        repeat (3) @(posedge clk) #1;
        chk("idle_after", busy, 0);
        chk("done_pulses", done_cnt, 1);
        chk("busy_cycles", busy_cyc, exp_busy);
        chk("pairs_left", sb.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("pairs_seen", hs_cnt, 25);
        chk("done_gap", done_cyc - last_hs_cyc, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < 25; i++) begin
            ram[i]      = 9'(i + 1);
            ram[25 + i] = 9'(i + 26);
        end
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;

        run_job(-1, -1, 1'b0, -1, 100);
        run_job(7, -1, 1'b0, -1, 103);
        run_job(-1, 3, 1'b1, -1, 100);
        run_job(-1, -1, 1'b0, 12, 0);
        repeat (2) @(posedge clk) #1;
        chk("post_rst_idle", busy, 0);
        run_job(-1, -1, 1'b0, -1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
